imem_port_arbiter: RTL

//   Shares the single port of the synchronous instruction memory between two requesters:
//   the CPU fetch unit (F) and the firmware loader/debug port (L).

---
 rtl/imem_pkg.sv | 20 ++
 rtl/imem_arb_age_cnt.sv | 39 +++
 rtl/imem_port_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
// Holds the read-owner encoding and the loader access-type helper.
package imem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int MASK_W     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_F = 2'd1,
        RESP_L = 2'd2
    } owner_e;

    // An all-zero byte mask turns a loader write into a read.
    function automatic logic is_write(input logic we, input logic [MASK_W-1:0] mask);
        return we && (mask != 4'b0000);
    endfunction

endpackage

// File: rtl/imem_arb_age_cnt.sv
// Saturating count of consecutive cycles the loader has been blocked.
// force_win rises once the count reaches MAX_WAIT so the loader cannot starve.
module imem_arb_age_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       l_req,
    input  logic       l_gnt,
    output logic       force_win
);

    logic [3:0] wait_cnt_r;
    logic [3:0] wait_cnt_nxt_s;

    // Next count: clear when not waiting, otherwise count up to the limit.
    always_comb begin
        wait_cnt_nxt_s = wait_cnt_r;
        if (!l_req || l_gnt) begin
            wait_cnt_nxt_s = 4'd0;
        end else if (wait_cnt_r < 4'(MAX_WAIT)) begin
            wait_cnt_nxt_s = wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_nxt_s = wait_cnt_r;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt_r <= 4'd0;
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    assign force_win = (wait_cnt_r == 4'(MAX_WAIT));

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one synchronous instruction-memory port between fetch (F) and loader (L),
// granting per cycle and steering the 1-cycle read data back to the issuing requester.
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic [MASK_W-1:0] l_mask,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_renable,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_mask,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_e            owner_r;
    owner_e            owner_nxt_s;
    logic [ADDR_W-1:0] addr_hold_r;
    logic [DATA_W-1:0] wdata_hold_r;
    logic              force_win_s;
    logic              l_write_s;
    logic              f_gnt_s;
    logic              l_gnt_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              mem_renable_s;
    logic [MASK_W-1:0] mem_mask_s;
    logic              addr_lsb_unused_s;

    assign addr_lsb_unused_s = ^{f_addr[1:0], l_addr[1:0]};
    assign l_write_s         = is_write(l_we, l_mask);

    imem_arb_age_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age_cnt (
        .clk       (clk),
        .resetn    (resetn),
        .l_req     (l_req),
        .l_gnt     (l_gnt_s),
        .force_win (force_win_s)
    );

    // Grant: F by default, L when F is idle or L has waited long enough.
    // Grants are gated by resetn so every output drops as soon as reset asserts.
    always_comb begin
        f_gnt_s = 1'b0;
        l_gnt_s = 1'b0;
        if (!resetn) begin
            f_gnt_s = 1'b0;
            l_gnt_s = 1'b0;
        end else if (l_req && (!f_req || force_win_s)) begin
            l_gnt_s = 1'b1;
        end else if (f_req) begin
            f_gnt_s = 1'b1;
        end else begin
            f_gnt_s = 1'b0;
        end
    end

    // Memory-side mux from the winner; address and write data hold when idle.
    always_comb begin
        mem_addr_s    = addr_hold_r;
        mem_wdata_s   = wdata_hold_r;
        mem_renable_s = 1'b0;
        mem_mask_s    = 4'b0000;
        if (f_gnt_s) begin
            mem_addr_s    = {f_addr[ADDR_W-1:2], 2'b00};
            mem_renable_s = 1'b1;
        end else if (l_gnt_s) begin
            mem_addr_s = {l_addr[ADDR_W-1:2], 2'b00};
            if (l_write_s) begin
                mem_mask_s  = l_mask;
                mem_wdata_s = l_wdata;
            end else begin
                mem_renable_s = 1'b1;
            end
        end else begin
            mem_renable_s = 1'b0;
        end
    end

    // Owner of the read that completes next cycle; writes leave no owner.
    always_comb begin
        owner_nxt_s = IDLE;
        if (f_gnt_s) begin
            owner_nxt_s = RESP_F;
        end else if (l_gnt_s && !l_write_s) begin
            owner_nxt_s = RESP_L;
        end else begin
            owner_nxt_s = IDLE;
        end
    end

    // Owner state and held memory-side values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_r      <= IDLE;
            addr_hold_r  <= '0;
            wdata_hold_r <= '0;
        end else begin
            owner_r      <= owner_nxt_s;
            addr_hold_r  <= mem_addr_s;
            wdata_hold_r <= mem_wdata_s;
        end
    end

    // Response demux: only the owner sees data, the other side reads zero.
    always_comb begin
        f_rvalid = 1'b0;
        f_rdata  = '0;
        l_rvalid = 1'b0;
        l_rdata  = '0;
        case (owner_r)
            RESP_F: begin
                f_rvalid = 1'b1;
                f_rdata  = mem_rdata;
            end
            RESP_L: begin
                l_rvalid = 1'b1;
                l_rdata  = mem_rdata;
            end
            default: begin
                f_rvalid = 1'b0;
                l_rvalid = 1'b0;
            end
        endcase
    end

    assign f_gnt       = f_gnt_s;
    assign l_gnt       = l_gnt_s;
    assign mem_addr    = mem_addr_s;
    assign mem_wdata   = mem_wdata_s;
    assign mem_renable = mem_renable_s;
    assign mem_mask    = mem_mask_s;

endmodule
